core_inst_seq: RTL and testbench

CORE_INST_SEQ -- requirements
Module: core_inst_seq

---
 rtl/core_inst_seq.sv | 239 +++++++++++++++++++++++
 tb/tb_core_inst_seq.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_inst_seq.sv
// ---------------------------------------------------------------------------
// core_inst_seq
//
// Per-tile instruction sequencer for the attention core. One start request
// runs a complete tile:
//   LOADK : stream col K rows out of kmem into the MAC array
//   EXE   : stream total_cycle Q rows out of qmem through the MAC array
//   DRAIN : move total_cycle psum rows from the output FIFO into pmem
//   DONE  : one-cycle completion pulse, then back to IDLE
//
// The state, the counters and every output are registers. The next-cycle
// outputs are decoded from the next-cycle state, so the instruction word
// always matches the state it belongs to.
//
// Parameters
//   col          K rows loaded per tile (1..16)
//   total_cycle  Q rows executed and psum rows drained per tile (1..16)
//
// Ports
//   clk         sole clock, rising edge
//   reset_n     asynchronous active-low reset; forces IDLE with all outputs 0
//   start       one-cycle tile request, sampled only in IDLE
//   fifo_valid  output FIFO holds a row; sampled each edge while draining
//   inst[29:0]  core instruction word:
//                 [0] pmem_wr         [1] pmem_rd (unused, 0)
//                 [2] kmem_even_wr    [3] kmem_odd_wr (unused, 0)
//                 [4] kmem_even_rd    [5] kmem_odd_rd
//                 [6] qmem_even_wr    [7] qmem_odd_wr (unused, 0)
//                 [8] qmem_even_rd    [9] qmem_odd_rd
//                 [13:10] pmem_add    [17:14] qkmem_add
//                 [18] ofifo_rd       [19] mac_loadk   [20] mac_exe
//                 [29:21] norm/sfp controls (unused, 0)
//   busy        high in every state except IDLE
//   done        one-cycle pulse in the DONE state
//   bank        buffer half used by the current tile: 0=even, 1=odd
//
// Configuration macro
//   CORE_INST_SEQ_PINGPONG_EN  defined: bank toggles when a tile completes,
//                              so consecutive tiles alternate halves.
//                              undefined: bank is held at 0 and the odd
//                              read bits are never set.
// ---------------------------------------------------------------------------
module core_inst_seq #(
    parameter int col         = 8,
    parameter int total_cycle = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        fifo_valid,
    output logic [29:0] inst,
    output logic        busy,
    output logic        done,
    output logic        bank
);

    // State encoding kept as plain constants for compatibility with the
    // existing core control code.
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOADK = 3'd1;
    localparam logic [2:0] S_EXE   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Counters are 5 bits so that a count of 16 is representable without
    // wrapping the 4-bit address fields.
    localparam logic [4:0] col_cnt = 5'(col);
    localparam logic [4:0] tc_cnt  = 5'(total_cycle);

    // Instruction bit positions
    localparam int PMEM_WR      = 0;
    localparam int KMEM_EVEN_RD = 4;
    localparam int KMEM_ODD_RD  = 5;
    localparam int QMEM_EVEN_RD = 8;
    localparam int QMEM_ODD_RD  = 9;
    localparam int PMEM_ADD_LO  = 10;
    localparam int QK_ADD_LO    = 14;
    localparam int OFIFO_RD     = 18;
    localparam int MAC_LOADK    = 19;
    localparam int MAC_EXE      = 20;

    logic [2:0]  state,  state_n;
    logic [4:0]  step,   step_n;    // LOADK / EXE step index
    logic [4:0]  rd_cnt, rd_cnt_n;  // ofifo reads issued this tile
    logic [4:0]  wr_cnt, wr_cnt_n;  // pmem writes issued this tile
    logic        bank_n;
    logic [29:0] inst_n;
    logic        busy_n;
    logic        done_n;

    // -----------------------------------------------------------------------
    // Next-state and counter logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_n  = state;
        step_n   = step;
        rd_cnt_n = rd_cnt;
        wr_cnt_n = wr_cnt;
        bank_n   = bank;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n  = S_LOADK;
                    step_n   = 5'd0;
                    rd_cnt_n = 5'd0;
                    wr_cnt_n = 5'd0;
                end
            end

            // Step col is the trailing cycle that catches the last kmem
            // read, which arrives one cycle after it was issued.
            S_LOADK: begin
                if (step == col_cnt) begin
                    state_n = S_EXE;
                    step_n  = 5'd0;
                end else begin
                    step_n = step + 5'd1;
                end
            end

            S_EXE: begin
                if (step == tc_cnt) begin
                    state_n = S_DRAIN;
                    step_n  = 5'd0;
                end else begin
                    step_n = step + 5'd1;
                end
            end

            // Leave once the final pmem write is on the output this cycle.
            S_DRAIN: begin
                if (inst[PMEM_WR] && (wr_cnt == tc_cnt)) begin
                    state_n = S_DONE;
                end
            end

            S_DONE: begin
                state_n = S_IDLE;
`ifdef CORE_INST_SEQ_PINGPONG_EN
                bank_n  = ~bank;
`endif
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase

`ifndef CORE_INST_SEQ_PINGPONG_EN
        bank_n = 1'b0;
`endif

        // -------------------------------------------------------------------
        // Output decode for the cycle being entered
        // -------------------------------------------------------------------
        inst_n = '0;

        case (state_n)
            S_LOADK: begin
                if (step_n < col_cnt) begin
                    if (bank_n) inst_n[KMEM_ODD_RD]  = 1'b1;
                    else        inst_n[KMEM_EVEN_RD] = 1'b1;
                    inst_n[QK_ADD_LO +: 4] = step_n[3:0];
                end
                // Data read at step i-1 is on the SRAM output at step i.
                if (step_n != 5'd0) begin
                    inst_n[MAC_LOADK] = 1'b1;
                end
            end

            S_EXE: begin
                if (step_n < tc_cnt) begin
                    if (bank_n) inst_n[QMEM_ODD_RD]  = 1'b1;
                    else        inst_n[QMEM_EVEN_RD] = 1'b1;
                    inst_n[QK_ADD_LO +: 4] = step_n[3:0];
                end
                if (step_n != 5'd0) begin
                    inst_n[MAC_EXE] = 1'b1;
                end
            end

            S_DRAIN: begin
                // A FIFO read is issued for the cycle after fifo_valid is
                // seen high; no read is issued while it is low, however
                // long that lasts.
                if (fifo_valid && (rd_cnt < tc_cnt)) begin
                    inst_n[OFIFO_RD] = 1'b1;
                    rd_cnt_n         = rd_cnt + 5'd1;
                end
                // The row popped this cycle is written to pmem next cycle.
                if (inst[OFIFO_RD]) begin
                    inst_n[PMEM_WR]          = 1'b1;
                    inst_n[PMEM_ADD_LO +: 4] = wr_cnt[3:0];
                    wr_cnt_n                 = wr_cnt + 5'd1;
                end
            end

            default: begin
                inst_n = '0;
            end
        endcase

        busy_n = (state_n != S_IDLE);
        done_n = (state_n == S_DONE);
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // NOTE: every register, outputs included, is in the async reset so a
    // reset mid-tile drops inst/busy/done immediately, without a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            step   <= 5'd0;
            rd_cnt <= 5'd0;
            wr_cnt <= 5'd0;
            bank   <= 1'b0;
            inst   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            step   <= step_n;
            rd_cnt <= rd_cnt_n;
            wr_cnt <= wr_cnt_n;
            bank   <= bank_n;
            inst   <= inst_n;
            busy   <= busy_n;
            done   <= done_n;
        end
    end

endmodule

// File: tb/tb_core_inst_seq.sv
// ---------------------------------------------------------------------------
// tb_core_inst_seq
//
// Directed bench for core_inst_seq with col=8, total_cycle=8. Each tile is
// recorded cycle by cycle (cycle 1 = first cycle after start is taken) and
// compared against an expected trace built by the bench from the fifo_valid
// pattern it applied. Defining CORE_INST_SEQ_PINGPONG_EN for the bench as
// well as the RTL switches the expected bank sequence.
// ---------------------------------------------------------------------------
module tb_core_inst_seq;

    localparam int COL  = 8;
    localparam int TC   = 8;
    localparam int MAXC = 64;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        fifo_valid;
    logic [29:0] inst;
    logic        busy;
    logic        done;
    logic        bank;

    int total = 0;
    int bad   = 0;

    // Recorded trace of the last tile
    logic [29:0] tr_inst [0:MAXC-1];
    logic        tr_busy [0:MAXC-1];
    logic        tr_done [0:MAXC-1];
    logic        tr_bank [0:MAXC-1];
    logic        tr_fv   [0:MAXC-1];
    int          tr_len;

    // Expected trace
    logic [29:0] exp_inst [0:MAXC-1];
    logic        exp_busy [0:MAXC-1];
    logic        exp_done [0:MAXC-1];
    int          exp_len;

    logic        tile_bank;  // bank the next tile is expected to use
    logic        cur_bank;   // bank of the tile just recorded

    core_inst_seq #(.col(COL), .total_cycle(TC)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .fifo_valid (fifo_valid),
        .inst       (inst),
        .busy       (busy),
        .done       (done),
        .bank       (bank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // fifo_valid pattern: mode 0 always high; mode 1 low for cycles 19..21,
    // high 22..24, low 25..27, ... (toggling every 3 cycles in DRAIN).
    function automatic logic fv_of(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (c < 19) return 1'b0;
        return (((c - 19) / 3) % 2) == 1;
    endfunction

    // Issue start in the current IDLE cycle and record until one cycle past
    // done. Bounded by MAXC; a missing done shows up as a length mismatch.
    task automatic run_tile(input int mode, input bit poke_start);
        bit seen;
        seen     = 1'b0;
        tr_len   = 0;
        cur_bank = tile_bank;
        start    = 1'b1;
        for (int c = 1; c < MAXC; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (poke_start && c == 12) start = 1'b1;
            fifo_valid = fv_of(mode, c);
            tr_inst[c] = inst;
            tr_busy[c] = busy;
            tr_done[c] = done;
            tr_bank[c] = bank;
            tr_fv[c]   = fifo_valid;
            tr_len     = c;
            if (seen) break;
            if (done) seen = 1'b1;
        end
        start      = 1'b0;
        fifo_valid = 1'b0;
`ifdef CORE_INST_SEQ_PINGPONG_EN
        tile_bank = ~tile_bank;
`endif
    endtask

    // Expected trace from the tile timing rules and the recorded fifo_valid.
    task automatic build_expected(input logic b);
        int          c, reads, writes;
        logic        pend, rd;
        logic [29:0] w;
        for (int i = 0; i < MAXC; i++) begin
            exp_inst[i] = '0; exp_busy[i] = 1'b0; exp_done[i] = 1'b0;
        end
        for (int i = 1; i <= COL + 1; i++) begin      // LOADK, cycles 1..9
            w = '0;
            if (i <= COL) begin
                w[4 + int'(b)] = 1'b1;
                w[17:14] = 4'(i - 1);
            end
            if (i >= 2) w[19] = 1'b1;
            exp_inst[i] = w; exp_busy[i] = 1'b1;
        end
        for (int j = 0; j <= TC; j++) begin           // EXE, cycles 10..18
            w = '0;
            if (j < TC) begin
                w[8 + int'(b)] = 1'b1;
                w[17:14] = 4'(j);
            end
            if (j >= 1) w[20] = 1'b1;
            exp_inst[COL + 2 + j] = w; exp_busy[COL + 2 + j] = 1'b1;
        end
        c = COL + TC + 3;                             // first DRAIN cycle
        reads = 0; writes = 0; pend = 1'b0;
        while (c < MAXC - 2) begin
            rd = tr_fv[c - 1] && (reads < TC);
            w  = '0;
            if (rd) w[18] = 1'b1;
            if (pend) begin
                w[0] = 1'b1;
                w[13:10] = 4'(writes);
                writes++;
            end
            if (rd) reads++;
            pend = rd;
            exp_inst[c] = w; exp_busy[c] = 1'b1;
            c++;
            if (writes == TC) break;
        end
        exp_busy[c] = 1'b1; exp_done[c] = 1'b1;       // DONE
        exp_len = c + 1;                              // first IDLE cycle
    endtask

    task automatic test_reset;
        reset_n = 1'b0; start = 1'b0; fifo_valid = 1'b0;
        tile_bank = 1'b0;
        #1;
        total++;
        if (inst !== 30'd0 || busy !== 1'b0 || done !== 1'b0 || bank !== 1'b0) begin
            bad++;
            $display("FAIL reset_state inst=%h busy=%b done=%b bank=%b want 0/0/0/0",
                     inst, busy, done, bank);
        end
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (inst !== 30'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset inst=%h busy=%b want 0/0", inst, busy);
        end
    endtask

    task automatic test_loadk;
        int n4;
        run_tile(0, 1'b0);
        build_expected(cur_bank);
        n4 = 0;
        for (int c = 1; c <= COL + 2; c++) begin
            total++;
            if (tr_inst[c] !== exp_inst[c] || tr_busy[c] !== 1'b1) begin
                bad++;
                $display("FAIL loadk c=%0d inst=%h busy=%b want %h/1",
                         c, tr_inst[c], tr_busy[c], exp_inst[c]);
            end
            if (tr_inst[c][19]) n4++;
        end
        total++;
        if (n4 !== COL) begin
            bad++;
            $display("FAIL loadk_count mac_loadk cycles=%0d want %0d", n4, COL);
        end
    endtask

    task automatic test_exe;
        run_tile(0, 1'b0);
        build_expected(cur_bank);
        for (int c = COL + 2; c <= COL + TC + 3; c++) begin
            total++;
            if (tr_inst[c] !== exp_inst[c]) begin
                bad++;
                $display("FAIL exe c=%0d inst=%h want %h", c, tr_inst[c], exp_inst[c]);
            end
            total++;
            if (tr_inst[c][19] & tr_inst[c][20]) begin
                bad++;
                $display("FAIL exe_overlap c=%0d loadk=1 exe=1 want not both", c);
            end
        end
    endtask

    // Whole drain section plus done/idle, and the tile length.
    task automatic test_drain(input int mode, input string tag);
        int nrd, nwr, ndone;
        run_tile(mode, 1'b0);
        build_expected(cur_bank);
        total++;
        if (tr_len !== exp_len) begin
            bad++;
            $display("FAIL %s_len cycles=%0d want %0d", tag, tr_len, exp_len);
        end
        nrd = 0; nwr = 0; ndone = 0;
        for (int c = COL + TC + 3; c <= exp_len; c++) begin
            total++;
            if (tr_inst[c] !== exp_inst[c] || tr_done[c] !== exp_done[c] ||
                tr_busy[c] !== exp_busy[c]) begin
                bad++;
                $display("FAIL %s c=%0d inst=%h done=%b busy=%b want %h/%b/%b", tag, c,
                         tr_inst[c], tr_done[c], tr_busy[c], exp_inst[c], exp_done[c], exp_busy[c]);
            end
            if (tr_inst[c][18]) nrd++;
            if (tr_inst[c][0])  nwr++;
            if (tr_done[c])     ndone++;
        end
        total++;
        if (nrd !== TC || nwr !== TC || ndone !== 1) begin
            bad++;
            $display("FAIL %s_counts rd=%0d wr=%0d done=%0d want %0d/%0d/1",
                     tag, nrd, nwr, ndone, TC, TC);
        end
    endtask

    task automatic test_start_ignored;
        int ndone;
        run_tile(0, 1'b1);
        build_expected(cur_bank);
        total++;
        if (tr_len !== exp_len) begin
            bad++;
            $display("FAIL start_ign_len cycles=%0d want %0d", tr_len, exp_len);
        end
        ndone = 0;
        for (int c = 1; c <= tr_len; c++) if (tr_done[c]) ndone++;
        repeat (4) begin
            @(posedge clk); #1;
            if (busy || done) ndone = ndone + 10;
        end
        total++;
        if (ndone !== 1) begin
            bad++;
            $display("FAIL start_ign_done score=%0d want 1 (single done, then idle)", ndone);
        end
    endtask

    task automatic test_back_to_back;
        logic b1, b2;
        logic e1, e2;
`ifdef CORE_INST_SEQ_PINGPONG_EN
        e1 = tile_bank; e2 = ~tile_bank;
`else
        e1 = 1'b0; e2 = 1'b0;
`endif
        run_tile(0, 1'b0);
        b1 = tr_bank[1];
        total++;
        if (tr_inst[1][4] !== ~e1 || tr_inst[1][5] !== e1 ||
            tr_inst[10][8] !== ~e1 || tr_inst[10][9] !== e1 || b1 !== e1) begin
            bad++;
            $display("FAIL b2b_tile1 k_ev/od=%b%b q_ev/od=%b%b bank=%b want bank %b",
                     tr_inst[1][4], tr_inst[1][5], tr_inst[10][8], tr_inst[10][9], b1, e1);
        end
        run_tile(0, 1'b0);
        b2 = tr_bank[1];
        build_expected(e2);
        total++;
        if (tr_inst[1][4] !== ~e2 || tr_inst[1][5] !== e2 ||
            tr_inst[10][8] !== ~e2 || tr_inst[10][9] !== e2 || b2 !== e2) begin
            bad++;
            $display("FAIL b2b_tile2 k_ev/od=%b%b q_ev/od=%b%b bank=%b want bank %b",
                     tr_inst[1][4], tr_inst[1][5], tr_inst[10][8], tr_inst[10][9], b2, e2);
        end
        for (int c = 1; c <= exp_len; c++) begin
            total++;
            if (tr_inst[c] !== exp_inst[c]) begin
                bad++;
                $display("FAIL b2b_trace c=%0d inst=%h want %h", c, tr_inst[c], exp_inst[c]);
            end
        end
    endtask

    task automatic test_reset_mid_exe;
        int viol;
        start = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        total++;
        if (busy !== 1'b1 || inst[20] !== 1'b1) begin
            bad++;
            $display("FAIL mid_exe_pre busy=%b mac_exe=%b want 1/1", busy, inst[20]);
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (inst !== 30'd0 || busy !== 1'b0 || done !== 1'b0 || bank !== 1'b0) begin
            bad++;
            $display("FAIL mid_exe_reset inst=%h busy=%b done=%b bank=%b want 0/0/0/0",
                     inst, busy, done, bank);
        end
        tile_bank = 1'b0;
        @(posedge clk);
        #3 reset_n = 1'b1;
        viol = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (busy !== 1'b0 || done !== 1'b0 || inst !== 30'd0) viol++;
        end
        total++;
        if (viol !== 0) begin
            bad++;
            $display("FAIL mid_exe_stays_idle bad_cycles=%0d want 0", viol);
        end
        run_tile(0, 1'b0);
        build_expected(cur_bank);
        total++;
        if (tr_len !== exp_len || tr_inst[1] !== exp_inst[1]) begin
            bad++;
            $display("FAIL mid_exe_resume len=%0d inst1=%h want %0d/%h",
                     tr_len, tr_inst[1], exp_len, exp_inst[1]);
        end
    endtask

    initial begin
        test_reset();
        test_loadk();
        test_exe();
        test_drain(0, "drain_full");
        test_drain(1, "drain_stall");
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_exe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
